// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle calculator ALU between NumReq requesters,
// with a start/done handshake to the ALU and a watchdog that aborts stuck operations.
package calc_pkg;
  typedef logic signed [15:0] num_t;
  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3} op_t;
endpackage

module alu_arbiter
  import calc_pkg::*;
#(
  parameter int NumReq        = 2,
  parameter int TimeoutCycles = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_valid_i,
  output logic [NumReq-1:0] req_ready_o,
  input  num_t              req_left_i  [NumReq],
  input  num_t              req_right_i [NumReq],
  input  op_t               req_op_i    [NumReq],
  output logic [NumReq-1:0] rsp_valid_o,
  output num_t              rsp_result_o,
  output logic              rsp_error_o,
  output logic              alu_start_o,
  output num_t              alu_left_o,
  output num_t              alu_right_o,
  output op_t               alu_op_o,
  input  logic              alu_done_i,
  input  num_t              alu_result_i
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int TmrW = $clog2(TimeoutCycles);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [IdxW-1:0]   rr, grant, grant_q;
  logic              found;
  logic [TmrW-1:0]   timer;
  logic              timeout;

  // Search from the round-robin pointer upward, wrapping at NumReq.
  always_comb begin : grant_search
    int idx;
    idx   = 0;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      idx = (int'(rr) + k) % NumReq;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        grant = IdxW'(idx);
      end
    end
  end

  assign timeout = (timer == TmrW'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready_o = '0;
    rsp_valid_o = '0;
    alu_start_o = 1'b0;
    case (state)
      IDLE: begin
        // Ready is gated by reset so no requester sees an accept while reset is held.
        if (found && !rst_i) begin
          req_ready_o[grant] = 1'b1;
          state_nxt          = START;
        end
      end
      START: begin
        alu_start_o = 1'b1;
        state_nxt   = WAIT;
      end
      WAIT: begin
        if (alu_done_i || timeout) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid_o[grant_q] = 1'b1;
        state_nxt            = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr           <= '0;
      grant_q      <= '0;
      timer        <= '0;
      alu_left_o   <= '0;
      alu_right_o  <= '0;
      alu_op_o     <= OP_ADD;
      rsp_result_o <= '0;
      rsp_error_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            alu_left_o  <= req_left_i[grant];
            alu_right_o <= req_right_i[grant];
            alu_op_o    <= req_op_i[grant];
            grant_q     <= grant;
            rr          <= (grant == IdxW'(NumReq - 1)) ? '0 : grant + 1'b1;
          end
        end
        START: timer <= '0;
        WAIT: begin
          // A done arriving on the final watchdog cycle still counts as success.
          if (alu_done_i) begin
            rsp_result_o <= alu_result_i;
            rsp_error_o  <= 1'b0;
          end else if (timeout) begin
            rsp_result_o <= '0;
            rsp_error_o  <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter: two requesters, watchdog shortened to 4 cycles.
module tb_alu_arbiter;
  import calc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid, req_ready, rsp_valid;
  num_t       req_left [2];
  num_t       req_right[2];
  op_t        req_op   [2];
  num_t       rsp_result, alu_left, alu_right, alu_result;
  logic       rsp_error, alu_start, alu_done;
  op_t        alu_op;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.NumReq(2), .TimeoutCycles(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_left_i   (req_left),
    .req_right_i  (req_right),
    .req_op_i     (req_op),
    .rsp_valid_o  (rsp_valid),
    .rsp_result_o (rsp_result),
    .rsp_error_o  (rsp_error),
    .alu_start_o  (alu_start),
    .alu_left_o   (alu_left),
    .alu_right_o  (alu_right),
    .alu_op_o     (alu_op),
    .alu_done_i   (alu_done),
    .alu_result_i (alu_result)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    req_valid = 2'b00;
    alu_done  = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  // Called in the START cycle: completes the operation with a done after one WAIT cycle.
  task automatic finish_op(input num_t res);
    step();
    alu_done   = 1'b1;
    alu_result = res;
    step();
    alu_done = 1'b0;
    step();
  endtask

  task automatic test_reset;
    step();
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    checks++; if (alu_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", alu_start); end
    checks++; if (rsp_valid !== 2'b00 || rsp_error !== 1'b0) begin errors++; $display("FAIL reset_rsp: got %b/%b want 00/0", rsp_valid, rsp_error); end
    checks++; if (alu_left !== 16'sd0 || alu_right !== 16'sd0 || rsp_result !== 16'sd0) begin errors++; $display("FAIL reset_data: got %0d %0d %0d want 0 0 0", alu_left, alu_right, rsp_result); end
    checks++; if (alu_op !== OP_ADD) begin errors++; $display("FAIL reset_op: got %0d want %0d", alu_op, OP_ADD); end
    req_valid = 2'b00;
  endtask

  task automatic test_single;
    do_reset();
    req_left[0] = 16'sd5; req_right[0] = 16'sd3; req_op[0] = OP_ADD;
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", req_ready); end
    step();
    checks++; if (alu_start !== 1'b1 || req_ready !== 2'b00) begin errors++; $display("FAIL single_start: got start=%b ready=%b want 1 00", alu_start, req_ready); end
    checks++; if (alu_left !== 16'sd5 || alu_right !== 16'sd3 || alu_op !== OP_ADD) begin errors++; $display("FAIL single_operands: got %0d %0d %0d want 5 3 0", alu_left, alu_right, alu_op); end
    req_valid = 2'b00;
    step();
    checks++; if (alu_start !== 1'b0) begin errors++; $display("FAIL single_start_pulse: got %b want 0", alu_start); end
    step();
    alu_done = 1'b1; alu_result = 16'sd8;
    step();
    alu_done = 1'b0;
    checks++; if (rsp_valid !== 2'b01 || rsp_result !== 16'sd8 || rsp_error !== 1'b0) begin errors++; $display("FAIL single_rsp: got %b %0d %b want 01 8 0", rsp_valid, rsp_result, rsp_error); end
    step();
    checks++; if (rsp_valid !== 2'b00 || rsp_result !== 16'sd8) begin errors++; $display("FAIL single_rsp_hold: got %b %0d want 00 8", rsp_valid, rsp_result); end
  endtask

  task automatic test_contention;
    int g;
    do_reset();
    req_left[0] = 16'sd10; req_right[0] = 16'sd1; req_op[0] = OP_SUB;
    req_left[1] = 16'sd20; req_right[1] = 16'sd2; req_op[1] = OP_MUL;
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      g = i % 2;
      #1;
      checks++; if (req_ready !== 2'(1 << g) || !$onehot(req_ready)) begin errors++; $display("FAIL contention_grant%0d: got %b want %b", i, req_ready, 2'(1 << g)); end
      step();
      checks++; if (alu_left !== ((g == 0) ? 16'sd10 : 16'sd20) || alu_op !== ((g == 0) ? OP_SUB : OP_MUL)) begin errors++; $display("FAIL contention_operand%0d: got %0d op %0d", i, alu_left, alu_op); end
      step();
      alu_done = 1'b1; alu_result = 16'(100 + i);
      step();
      alu_done = 1'b0;
      checks++; if (rsp_valid !== 2'(1 << g) || rsp_result !== 16'(100 + i)) begin errors++; $display("FAIL contention_rsp%0d: got %b %0d want %b %0d", i, rsp_valid, rsp_result, 2'(1 << g), 100 + i); end
      step();
    end
    req_valid = 2'b00;
  endtask

  task automatic test_rr_pointer;
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rr_only0: got %b want 01", req_ready); end
    step();
    req_valid = 2'b00;
    finish_op(16'sd1);
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rr_after0: got %b want 10", req_ready); end
    step();
    req_valid = 2'b00;
    finish_op(16'sd33);
  endtask

  task automatic test_timeout;
    req_left[1] = 16'sd7; req_right[1] = 16'sd9; req_op[1] = OP_DIV;
    req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL timeout_ready: got %b want 10", req_ready); end
    step();
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) step();
    checks++; if (rsp_valid !== 2'b00 || rsp_result !== 16'sd33) begin errors++; $display("FAIL timeout_early: got %b %0d want 00 33", rsp_valid, rsp_result); end
    step();
    checks++; if (rsp_valid !== 2'b10 || rsp_error !== 1'b1 || rsp_result !== 16'sd0) begin errors++; $display("FAIL timeout_rsp: got %b err %b %0d want 10 1 0", rsp_valid, rsp_error, rsp_result); end
    step();
    alu_done = 1'b1; alu_result = 16'sd55;
    step();
    alu_done = 1'b0;
    checks++; if (rsp_valid !== 2'b00 || rsp_error !== 1'b1 || rsp_result !== 16'sd0 || alu_start !== 1'b0) begin errors++; $display("FAIL timeout_late_done: got %b err %b %0d start %b want 00 1 0 0", rsp_valid, rsp_error, rsp_result, alu_start); end
  endtask

  task automatic test_coincide;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) step();
    alu_done = 1'b1; alu_result = -16'sd5;
    step();
    alu_done = 1'b0;
    checks++; if (rsp_valid !== 2'b01 || rsp_error !== 1'b0 || rsp_result !== -16'sd5) begin errors++; $display("FAIL coincide_rsp: got %b err %b %0d want 01 0 -5", rsp_valid, rsp_error, rsp_result); end
    step();
  endtask

  task automatic test_reset_wait;
    req_left[0] = 16'sd12; req_right[0] = 16'sd4; req_op[0] = OP_SUB;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    #3;
    rst = 1'b1;
    #1;
    checks++; if (alu_left !== 16'sd0 || alu_right !== 16'sd0 || alu_op !== OP_ADD || rsp_result !== 16'sd0) begin errors++; $display("FAIL rstwait_data: got %0d %0d %0d %0d want 0 0 0 0", alu_left, alu_right, alu_op, rsp_result); end
    checks++; if (rsp_valid !== 2'b00 || rsp_error !== 1'b0 || alu_start !== 1'b0) begin errors++; $display("FAIL rstwait_ctrl: got %b %b %b want 00 0 0", rsp_valid, rsp_error, alu_start); end
    step();
    alu_done = 1'b1; alu_result = 16'sd99;
    step();
    alu_done = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (rsp_valid !== 2'b00 || rsp_result !== 16'sd0) begin errors++; $display("FAIL rstwait_no_rsp%0d: got %b %0d want 00 0", i, rsp_valid, rsp_result); end
    end
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstwait_rr: got %b want 01", req_ready); end
    req_valid = 2'b00;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b00;
    alu_done   = 1'b0;
    alu_result = '0;
    for (int i = 0; i < 2; i++) begin
      req_left[i]  = '0;
      req_right[i] = '0;
      req_op[i]    = OP_ADD;
    end
    test_reset();
    test_single();
    test_contention();
    test_rr_pointer();
    test_timeout();
    test_coincide();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
